// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data memory, stalls upstream until ack or timeout,
// and loads the MEM/WB register (bubbles while stalled, cleared on flush).
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupt,
    input  logic        Memwrite_i,
    input  logic        MemToReg_i,
    input  logic        Regwrite_i,
    input  logic        lb_i,
    input  logic        jal_i,
    input  logic        lui_i,
    input  logic        halt_i,
    input  logic        eret_i,
    input  logic [4:0]  rw_i,
    input  logic [4:0]  desreg_i,
    input  logic [31:0] ALU_i,
    input  logic [31:0] mem_din_i,
    input  logic [31:0] wb_data_i,
    input  logic [31:0] PC_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [9:0]  dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic [4:0]  rw_o,
    output logic [4:0]  desreg_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] PC_o,
    output logic        Regwrite_o,
    output logic        halt_o,
    output logic        eret_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

    state_t      state_q = IDLE;
    state_t      state_d;
    logic [3:0]  cnt_q = '0;
    logic [3:0]  cnt_d;

    logic [4:0]  rw_q       = '0;
    logic [4:0]  desreg_q   = '0;
    logic [31:0] wb_data_q  = '0;
    logic [31:0] pc_q       = '0;
    logic        regwrite_q = 1'b0;
    logic        halt_q     = 1'b0;
    logic        eret_q     = 1'b0;

    logic        mem_op;
    logic        flush;
    logic        load_wb;
    logic        regwrite_d;
    logic [7:0]  rd_byte;
    logic [31:0] load_data;
    logic [31:0] wb_sel;
    logic        unused_ok;

    // jal/lui results arrive already folded into wb_data_i; upper address bits are outside the 1K-word RAM.
    assign unused_ok = ^{jal_i, lui_i, ALU_i[31:12]};

    assign mem_op     = Memwrite_i | MemToReg_i;
    assign flush      = interrupt | eret_q;
    assign dmem_addr  = ALU_i[11:2];
    assign dmem_wdata = mem_din_i;

    always_comb begin
        rd_byte = dmem_rdata[7:0];
        case (ALU_i[1:0])
            2'd0: rd_byte = dmem_rdata[7:0];
            2'd1: rd_byte = dmem_rdata[15:8];
            2'd2: rd_byte = dmem_rdata[23:16];
            2'd3: rd_byte = dmem_rdata[31:24];
            default: rd_byte = dmem_rdata[7:0];
        endcase
    end

    assign load_data = lb_i ? {{24{rd_byte[7]}}, rd_byte} : dmem_rdata;
    assign wb_sel    = MemToReg_i ? load_data : wb_data_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_o    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        bus_err_o  = 1'b0;
        load_wb    = 1'b0;
        regwrite_d = Regwrite_i;
        case (state_q)
            IDLE: begin
                if (mem_op && !flush) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                    stall_o = 1'b1;
                end else begin
                    load_wb = 1'b1;
                end
            end
            ACCESS: begin
                dmem_req = 1'b1;
                dmem_we  = Memwrite_i;
                if (dmem_ack) begin
                    load_wb = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    // The counter hits 15 on this edge: fifteen unacknowledged cycles is the limit.
                    if (cnt_q == 4'd14) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                bus_err_o  = 1'b1;
                load_wb    = 1'b1;
                regwrite_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rw_q       <= '0;
            desreg_q   <= '0;
            wb_data_q  <= '0;
            pc_q       <= '0;
            regwrite_q <= 1'b0;
            halt_q     <= 1'b0;
            eret_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Flushes and stall bubbles both leave an all-zero MEM/WB entry.
            if (flush || !load_wb) begin
                rw_q       <= '0;
                desreg_q   <= '0;
                wb_data_q  <= '0;
                pc_q       <= '0;
                regwrite_q <= 1'b0;
                halt_q     <= 1'b0;
                eret_q     <= 1'b0;
            end else begin
                rw_q       <= rw_i;
                desreg_q   <= desreg_i;
                wb_data_q  <= wb_sel;
                pc_q       <= PC_i;
                regwrite_q <= regwrite_d;
                halt_q     <= halt_i;
                eret_q     <= eret_i;
            end
        end
    end

    assign rw_o       = rw_q;
    assign desreg_o   = desreg_q;
    assign wb_data_o  = wb_data_q;
    assign PC_o       = pc_q;
    assign Regwrite_o = regwrite_q;
    assign halt_o     = halt_q;
    assign eret_o     = eret_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB entries are queued as each cycle is driven
// and compared after the edge that should produce them.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        interrupt = 1'b0;
    logic        Memwrite_i = 1'b0, MemToReg_i = 1'b0, Regwrite_i = 1'b0, lb_i = 1'b0;
    logic        jal_i = 1'b0, lui_i = 1'b0, halt_i = 1'b0, eret_i = 1'b0;
    logic [4:0]  rw_i = '0, desreg_i = '0;
    logic [31:0] ALU_i = '0, mem_din_i = '0, wb_data_i = '0, PC_i = '0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, dmem_we, stall_o, bus_err_o;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [4:0]  rw_o, desreg_o;
    logic [31:0] wb_data_o, PC_o;
    logic        Regwrite_o, halt_o, eret_o;

    typedef struct packed {
        logic [4:0]  rw;
        logic [4:0]  desreg;
        logic [31:0] wb;
        logic [31:0] pc;
        logic        regwrite;
        logic        halt;
        logic        eret;
    } wb_t;

    wb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .interrupt(interrupt),
        .Memwrite_i(Memwrite_i), .MemToReg_i(MemToReg_i), .Regwrite_i(Regwrite_i), .lb_i(lb_i),
        .jal_i(jal_i), .lui_i(lui_i), .halt_i(halt_i), .eret_i(eret_i),
        .rw_i(rw_i), .desreg_i(desreg_i), .ALU_i(ALU_i), .mem_din_i(mem_din_i),
        .wb_data_i(wb_data_i), .PC_i(PC_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_o(stall_o), .bus_err_o(bus_err_o),
        .rw_o(rw_o), .desreg_o(desreg_o), .wb_data_o(wb_data_o), .PC_o(PC_o),
        .Regwrite_o(Regwrite_o), .halt_o(halt_o), .eret_o(eret_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rw, input logic [31:0] wb, input logic [31:0] pc,
                        input logic regwrite, input logic halt, input logic eret);
        wb_t e;
        e.rw = rw; e.desreg = rw; e.wb = wb; e.pc = pc;
        e.regwrite = regwrite; e.halt = halt; e.eret = eret;
        sb_q.push_back(e);
    endtask

    task automatic push_bubble();
        push(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc(input string tag);
        wb_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed wb_data %h expected an entry", tag, wb_data_o);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".rw"},       32'(rw_o),       32'(e.rw));
            chk({tag, ".desreg"},   32'(desreg_o),   32'(e.desreg));
            chk({tag, ".wb_data"},  wb_data_o,       e.wb);
            chk({tag, ".pc"},       PC_o,            e.pc);
            chk({tag, ".regwrite"}, 32'(Regwrite_o), 32'(e.regwrite));
            chk({tag, ".halt"},     32'(halt_o),     32'(e.halt));
            chk({tag, ".eret"},     32'(eret_o),     32'(e.eret));
        end
    endtask

    task automatic set_nop();
        interrupt = 0; Memwrite_i = 0; MemToReg_i = 0; Regwrite_i = 0; lb_i = 0;
        jal_i = 0; lui_i = 0; halt_i = 0; eret_i = 0;
        rw_i = '0; desreg_i = '0; ALU_i = '0; mem_din_i = '0; wb_data_i = '0; PC_i = '0;
        dmem_rdata = '0; dmem_ack = 0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] alu, input logic lb,
                           input logic [31:0] rdata, input logic [31:0] exp,
                           input logic [31:0] pc, input int acc_cycles);
        int stalls;
        stalls = 0;
        set_nop();
        MemToReg_i = 1; Regwrite_i = 1; lb_i = lb; ALU_i = alu;
        rw_i = 5'd5; desreg_i = 5'd5; PC_i = pc; wb_data_i = 32'h1111_1111;
        dmem_rdata = 32'hBAD0_BAD0;
        #1;
        chk({tag, ".addr"}, 32'(dmem_addr), 32'(alu[11:2]));
        chk({tag, ".req_idle"}, 32'(dmem_req), 32'd0);
        if (stall_o) stalls++;
        push_bubble();
        cyc({tag, ".idle"});
        for (int i = 1; i <= acc_cycles; i++) begin
            if (i == acc_cycles) begin
                dmem_ack = 1; dmem_rdata = rdata;
            end
            #1;
            chk({tag, ".req"}, 32'(dmem_req), 32'd1);
            chk({tag, ".we"},  32'(dmem_we),  32'd0);
            if (stall_o) stalls++;
            if (i == acc_cycles) push(5'd5, exp, pc, 1'b1, 1'b0, 1'b0);
            else                 push_bubble();
            cyc({tag, ".acc"});
        end
        dmem_ack = 0;
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(acc_cycles));
    endtask

    task automatic do_store_timeout(input string tag, input logic intr_last);
        set_nop();
        Memwrite_i = 1; Regwrite_i = 1; rw_i = 5'd7; desreg_i = 5'd7; wb_data_i = 32'h55;
        ALU_i = 32'h20; mem_din_i = 32'hCAFE_F00D; PC_i = 32'h10C;
        #1;
        chk({tag, ".stall_idle"}, 32'(stall_o), 32'd1);
        push_bubble();
        cyc({tag, ".idle"});
        for (int i = 0; i < 15; i++) begin
            if (intr_last && i == 14) interrupt = 1;
            #1;
            chk({tag, ".req"},   32'(dmem_req),   32'd1);
            chk({tag, ".we"},    32'(dmem_we),    32'd1);
            chk({tag, ".stall"}, 32'(stall_o),    32'd1);
            chk({tag, ".berr0"}, 32'(bus_err_o),  32'd0);
            chk({tag, ".wdata"}, dmem_wdata,      32'hCAFE_F00D);
            chk({tag, ".addr"},  32'(dmem_addr),  32'd8);
            push_bubble();
            cyc({tag, ".acc"});
        end
        if (!intr_last) begin
            #1;
            chk({tag, ".berr"},      32'(bus_err_o), 32'd1);
            chk({tag, ".stall_err"}, 32'(stall_o),   32'd0);
            chk({tag, ".req_err"},   32'(dmem_req),  32'd0);
            push(5'd7, 32'h55, 32'h10C, 1'b0, 1'b0, 1'b0);
            cyc({tag, ".err"});
        end
        set_nop();
        #1;
        chk({tag, ".berr_after"},  32'(bus_err_o), 32'd0);
        chk({tag, ".stall_after"}, 32'(stall_o),   32'd0);
        chk({tag, ".req_after"},   32'(dmem_req),  32'd0);
    endtask

    initial begin
        // Power-up values, before any reset edge.
        #1;
        chk("t0.wb_data",  wb_data_o,         32'h0);
        chk("t0.regwrite", 32'(Regwrite_o),   32'd0);
        chk("t0.req",      32'(dmem_req),     32'd0);
        chk("t0.stall",    32'(stall_o),      32'd0);
        chk("t0.berr",     32'(bus_err_o),    32'd0);

        // Reset wins over a live instruction, interrupt and ack.
        rst = 1; Regwrite_i = 1; wb_data_i = 32'h5; rw_i = 5'd2; interrupt = 1; dmem_ack = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.regwrite", 32'(Regwrite_o), 32'd0);
        chk("rst.wb_data",  wb_data_o,       32'h0);
        chk("rst.rw",       32'(rw_o),       32'd0);
        chk("rst.req",      32'(dmem_req),   32'd0);
        rst = 0;
        set_nop();

        // Plain ALU result passes straight through.
        Regwrite_i = 1; wb_data_i = 32'h7; rw_i = 5'd3; desreg_i = 5'd3; PC_i = 32'h100;
        #1;
        chk("alu.stall", 32'(stall_o), 32'd0);
        push(5'd3, 32'h7, 32'h100, 1'b1, 1'b0, 1'b0);
        cyc("alu");

        // Halt bit is carried.
        set_nop();
        halt_i = 1; rw_i = 5'd4; desreg_i = 5'd4; wb_data_i = 32'hA5A5_0000; PC_i = 32'h1FC;
        push(5'd4, 32'hA5A5_0000, 32'h1FC, 1'b0, 1'b1, 1'b0);
        cyc("halt");

        do_load("lw",     32'h10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h104, 3);
        do_load("lb3",    32'h13, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80, 32'h108, 1);
        do_load("lb1",    32'h11, 1'b1, 32'h80FF_1234, 32'h0000_0012, 32'h10C, 1);
        do_load("lb0",    32'h10, 1'b1, 32'h80FF_1234, 32'h0000_0034, 32'h110, 1);
        do_load("lb2",    32'h12, 1'b1, 32'h80FF_1234, 32'hFFFF_FFFF, 32'h114, 2);
        do_load("lw_mis", 32'h13, 1'b0, 32'h80FF_1234, 32'h80FF_1234, 32'h118, 1);

        do_store_timeout("sw_to", 1'b0);
        do_store_timeout("sw_to_intr", 1'b1);

        // Interrupt together with ack in the 2nd ACCESS cycle: flush wins.
        set_nop();
        MemToReg_i = 1; Regwrite_i = 1; ALU_i = 32'h30; rw_i = 5'd8; desreg_i = 5'd8; PC_i = 32'h120;
        push_bubble();
        cyc("intr.idle");
        push_bubble();
        cyc("intr.acc1");
        interrupt = 1; dmem_ack = 1; dmem_rdata = 32'h1234_5678;
        push_bubble();
        cyc("intr.acc2");
        interrupt = 0; dmem_ack = 0;
        #1;
        chk("intr.req_after",   32'(dmem_req), 32'd0);
        chk("intr.stall_after", 32'(stall_o),  32'd1);
        set_nop();

        // Interrupt on an ALU op squashes it.
        Regwrite_i = 1; wb_data_i = 32'h99; rw_i = 5'd9; desreg_i = 5'd9; PC_i = 32'h124; interrupt = 1;
        push_bubble();
        cyc("intr_alu");

        // eret passes through once, then flushes the next instruction.
        set_nop();
        eret_i = 1; Regwrite_i = 1; wb_data_i = 32'h9; rw_i = 5'd9; desreg_i = 5'd9; PC_i = 32'h128;
        push(5'd9, 32'h9, 32'h128, 1'b1, 1'b0, 1'b1);
        cyc("eret");
        set_nop();
        Regwrite_i = 1; wb_data_i = 32'hA; rw_i = 5'd10; desreg_i = 5'd10; PC_i = 32'h12C;
        push_bubble();
        cyc("eret_flush");
        push(5'd10, 32'hA, 32'h12C, 1'b1, 1'b0, 1'b0);
        cyc("post_eret");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 interrupt  input  1  flush request from the interrupt controller.
REQ-004 Memwrite_i, MemToReg_i, Regwrite_i, lb_i, jal_i, lui_i, halt_i, eret_i  input  1 each  control bits from the EX/MEM register.
REQ-005 rw_i, desreg_i  input  5 each  destination register number; desreg_i is used for forwarding.
REQ-006 ALU_i, mem_din_i, wb_data_i, PC_i  input  32 each  address, store data, precomputed non-load writeback value, PC.
REQ-007 dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-008 dmem_addr  output  10  word address; equals ALU_i[11:2].
REQ-009 dmem_wdata  output  32  store data; equals mem_din_i.
REQ-010 dmem_rdata  input  32  read data, valid in the cycle dmem_ack is high.
REQ-011 dmem_ack  input  1  single-cycle completion strobe.
REQ-012 stall_o  output  1  holds the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 bus_err_o  output  1  one-cycle pulse on memory timeout.
REQ-014 MEM/WB register outputs:
- rw_o, desreg_o: 5 bits each.
- wb_data_o, PC_o: 32 bits each.
- Regwrite_o, halt_o, eret_o: 1 bit each.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and ERR.
REQ-016 A mem op SHALL be defined as Memwrite_i | MemToReg_i.
REQ-017 IDLE SHALL behave as follows:
- A mem op with no flush moves the FSM to ACCESS on the next edge.
- A non-mem op loads MEM/WB directly, with 1-cycle latency.
REQ-018 In ACCESS, dmem_req SHALL be 1 and dmem_we SHALL equal Memwrite_i; both SHALL be 0 in every other state.
REQ-019 In ACCESS with dmem_ack=1, the FSM SHALL load MEM/WB and return to IDLE on the same edge.
REQ-020 stall_o SHALL equal (IDLE & mem op & ~flush) | (ACCESS & ~dmem_ack); it is combinational.
- Upstream holds its inputs stable while stall_o=1.
REQ-021 While stall_o=1, MEM/WB SHALL load a bubble: Regwrite_o=0, halt_o=0, eret_o=0, and all other fields 0.
REQ-022 A 4-bit timeout counter SHALL behave as follows:
- It clears on entering ACCESS and increments each ACCESS cycle without ack.
- When it reaches 15 with no ack, the FSM moves to ERR.
REQ-023 ERR SHALL last one cycle, during which:
- bus_err_o=1 and stall_o=0.
- MEM/WB loads the instruction with Regwrite_o forced to 0.
- The next state is IDLE.
REQ-024 Load data SHALL be selected as follows:
- lb_i=0: the full dmem_rdata word.
- lb_i=1: byte ALU_i[1:0] of dmem_rdata (0 = bits 7:0, 3 = bits 31:24), sign-extended to 32 bits.
REQ-025 wb_data_o SHALL load the selected load data when MemToReg_i=1, and wb_data_i otherwise.
REQ-026 Flush SHALL be defined as interrupt | eret_o.
REQ-027 On a flush, the next edge SHALL clear all MEM/WB outputs, force the FSM to IDLE, clear the counter and drop dmem_req.
- This applies even in the middle of ACCESS.
- A store already acknowledged is not undone.
REQ-028 A flush SHALL take priority over dmem_ack and over the timeout when they occur in the same cycle.
REQ-029 ALU_i[1:0] SHALL be ignored for word accesses; there is no misalignment trap.

Reset
REQ-030 When rst=1 at an edge:
- State goes to IDLE and the counter to 0.
- All MEM/WB outputs go to 0, and bus_err_o goes to 0.
- dmem_req and dmem_we are 0 from that edge.
REQ-031 rst SHALL have priority over interrupt, eret_o and dmem_ack.
REQ-032 All outputs SHALL also be 0 at time zero, before the first reset.

Verification
REQ-033 ALU-op: Regwrite_i=1, wb_data_i=0x00000007, rw_i=3, no mem op -> next cycle wb_data_o=7, rw_o=3, Regwrite_o=1, stall_o=0.
REQ-034 lw: ALU_i=0x0000_0010, ack arrives in the 3rd ACCESS cycle with dmem_rdata=0xDEADBEEF ->
- dmem_addr=4.
- stall_o is high for 3 cycles.
- wb_data_o=0xDEADBEEF on the following cycle.
REQ-035 lb: ALU_i=0x13, dmem_rdata=0x80FF1234 -> wb_data_o=0xFFFFFF80.
- The same load with ALU_i=0x11 gives 0x00000012.
REQ-036 sw with no ack for 15 ACCESS cycles -> bus_err_o pulses one cycle, Regwrite_o=0, FSM returns to IDLE, stall_o=0.
REQ-037 interrupt=1 in the 2nd ACCESS cycle together with dmem_ack=1 -> next edge:
- All MEM/WB outputs are 0, the FSM is in IDLE, and dmem_req=0.
REQ-038 eret_i=1 on a non-mem op -> eret_o=1 for one cycle, then all MEM/WB outputs clear on the following edge.
